sha3_256_hls_udiv_59ns_31ns_29_seq: RTL and testbench
=====================================================

Name: sha3_256_hls_udiv_59ns_31ns_29_seq

Overview:
Iterative unsigned divider that inverts the 29x31->59 pipelined multiplier path. It accepts a 59-bit dividend and a 31-bit divisor and returns a 29-bit quotient and a 31-bit remainder. The core is a restoring divider that retires one quotient bit per enabled cycle. It sits beside the multiplier in the sha3_256_hls datapath and uses valid/ready handshakes on both the input and output sides.

Parameters:
ID, 1, instance tag; no functional effect
din0_WIDTH, 59, dividend width
din1_WIDTH, 31, divisor width
quot_WIDTH, 29, quotient width; also the iteration count
rem_WIDTH, 31, remainder width; must equal din1_WIDTH

Ports:
clk  in  1  clock; rising edge
reset  in  1  asynchronous, active-low reset; low clears all state
ce  in  1  clock enable; when low, all state and outputs hold
in_valid  in  1  operands are presented
in_ready  out  1  block can accept operands
din0  in  din0_WIDTH  dividend, unsigned
din1  in  din1_WIDTH  divisor, unsigned
out_valid  out  1  result is presented
out_ready  in  1  consumer accepts the result
quot  out  quot_WIDTH  quotient
rem  out  rem_WIDTH  remainder
div_by_zero  out  1  result flag: divisor was 0
overflow  out  1  result flag: true quotient does not fit in quot_WIDTH bits

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0.
  - quot, rem, div_by_zero, overflow = 0; iteration counter = 0.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is produced.
- All sequential updates are gated by ce. With ce=0, nothing changes, including handshake acceptance.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept in IDLE when in_valid & ce:
  - Latch divisor D and dividend low part L = din0[quot_WIDTH-1:0].
  - Partial remainder P (width din1_WIDTH+1) = din0[din0_WIDTH-1:quot_WIDTH], zero-extended.
  - Compute the exception flags:
    - dz = (din1==0)
    - ov = !dz & (din0[din0_WIDTH-1:quot_WIDTH] >= din1)
  - If dz or ov: next state is DONE.
    - dz: quot = all ones, rem = din0[rem_WIDTH-1:0].
    - ov: quot = all ones, rem = 0.
  - Otherwise: next state is RUN, counter = quot_WIDTH-1.
- RUN, per enabled cycle:
  - T = {P[din1_WIDTH-1:0], L[msb]}; L shifts left by 1.
  - If T >= D: P = T-D and shift quotient bit 1 into the LSB of Q. Otherwise P = T and shift in 0.
  - When the counter reaches 0, go to DONE; counter decrements otherwise.
  - RUN lasts exactly quot_WIDTH enabled cycles.
- Latency:
  - Normal case: out_valid rises 1+quot_WIDTH enabled cycles after the accept edge (30 at defaults).
  - Exception case: out_valid rises on the enabled cycle after the accept edge.
- DONE:
  - quot=Q, rem=P[rem_WIDTH-1:0], and both flags are held stable until out_valid & out_ready & ce.
  - On that handshake, go to IDLE. Outputs keep their last values; only out_valid drops.
  - out_ready asserted while not in DONE is ignored.
- No back-to-back overlap: a new operand is accepted no earlier than the cycle after the result handshake. Throughput is 1 op per quot_WIDTH+2 cycles.
- Invariants:
  - For non-exception results: din0 == quot*din1 + rem, with rem < din1.
  - in_ready and out_valid are never both 1.

Decomposition:
- Shared package sha3_256_hls_div_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - width constants (59/31/29)
  - the all-ones quotient constant
- One natural sub-module, sha3_256_hls_udiv_step: combinational compare/subtract stage of width din1_WIDTH+1. It takes P, the next dividend bit and D, and returns next P and the quotient bit. The top level holds the FSM, counter and registers.

Test Plan:
1. Multiplier round-trip: din0=0x0ABCDEF*0x12345678 (exact product), din1=0x12345678 -> after 30 cycles: quot=0x0ABCDEF, rem=0, flags 0.
2. Remainder case: din0=1000003, din1=7 -> quot=142857, rem=4. out_ready held low 5 cycles -> outputs are stable and in_ready stays 0.
3. Divide by zero: din0=0x155, din1=0 -> next cycle out_valid=1, div_by_zero=1, quot=0x1FFFFFFF, rem=0x155.
4. Overflow: din0=2^58, din1=1 -> overflow=1, quot=0x1FFFFFFF, rem=0 on the next cycle. Boundary: din0=2^29-1, din1=1 -> no overflow, quot=0x1FFFFFFF.
5. ce gating: toggle ce 50% during RUN -> out_valid appears after exactly 30 ce-high cycles and the result is unchanged.
6. Reset mid-RUN: assert reset low at iteration 10 -> state IDLE, out_valid=0, in_ready=1 immediately. A subsequent op (100/9) -> quot=11, rem=1.

Source files
------------

// File: rtl/sha3_256_hls_div_pkg.sv
// sha3_256_hls_div_pkg: shared FSM state, widths and constants for the iterative unsigned divider
package sha3_256_hls_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DIN0_W = 59;
    localparam int DIN1_W = 31;
    localparam int QUOT_W = 29;
    localparam logic [QUOT_W-1:0] QUOT_ONES = '1;
endpackage

// File: rtl/sha3_256_hls_udiv_step.sv
// sha3_256_hls_udiv_step: one restoring-division step (shift in a dividend bit, compare, subtract)
// Ports: p (partial remainder), din_bit (next dividend bit), d (divisor) -> p_nxt, q_bit
module sha3_256_hls_udiv_step
    import sha3_256_hls_div_pkg::*;
#(
    parameter int W = DIN1_W + 1
) (
    input  logic [W-1:0] p,
    input  logic         din_bit,
    input  logic [W-2:0] d,
    output logic [W-1:0] p_nxt,
    output logic         q_bit
);
    logic [W:0] t;
    // p stays below d, so its top bit is always zero and keeping it in t is harmless
    assign t     = {p, din_bit};
    assign q_bit = t >= (W+1)'(d);
    assign p_nxt = q_bit ? W'(t - (W+1)'(d)) : W'(t);
endmodule

// File: rtl/sha3_256_hls_udiv_59ns_31ns_29_seq.sv
// sha3_256_hls_udiv_59ns_31ns_29_seq: iterative restoring divider, 59b / 31b -> 29b quotient, 31b remainder
// Ports: clk, reset (async active-low), ce (global enable), in_valid/in_ready + din0/din1 operands,
//        out_valid/out_ready + quot/rem/div_by_zero/overflow result
module sha3_256_hls_udiv_59ns_31ns_29_seq
    import sha3_256_hls_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int quot_WIDTH = QUOT_W,
    parameter int rem_WIDTH  = DIN1_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [quot_WIDTH-1:0] quot,
    output logic [rem_WIDTH-1:0]  rem,
    output logic                  div_by_zero,
    output logic                  overflow
);
    localparam int PW = din1_WIDTH + 1;
    localparam int CW = $clog2(quot_WIDTH);

    if (rem_WIDTH != din1_WIDTH || quot_WIDTH < 2 || ID < 0) begin : g_bad_params
        $error("sha3_256_hls_udiv: rem_WIDTH must equal din1_WIDTH");
    end

    state_t                state, state_nxt;
    logic [din1_WIDTH-1:0] d;
    logic [quot_WIDTH-1:0] lq;
    logic [PW-1:0]         p, p_nxt, hi;
    logic [CW-1:0]         cnt;
    logic                  q_bit, dz, ov, accept, last;

    assign hi     = PW'(din0[din0_WIDTH-1:quot_WIDTH]);
    assign dz     = din1 == '0;
    assign ov     = !dz && hi >= {1'b0, din1};
    assign accept = ce && in_valid && state == IDLE;
    assign last   = state == RUN && cnt == '0;

    // lq holds the unconsumed dividend bits in its top and the quotient bits shifted in at the bottom
    sha3_256_hls_udiv_step #(.W(PW)) u_step (
        .p      (p),
        .din_bit(lq[quot_WIDTH-1]),
        .d      (d),
        .p_nxt  (p_nxt),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? ((dz || ov) ? DONE : RUN) : IDLE;
            RUN:     state_nxt = cnt == '0 ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d           <= '0;
            lq          <= '0;
            p           <= '0;
            cnt         <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            d   <= din1;
            lq  <= din0[quot_WIDTH-1:0];
            p   <= hi;
            cnt <= CW'(quot_WIDTH - 1);
            if (dz || ov) begin
                quot        <= '1;
                rem         <= dz ? din0[rem_WIDTH-1:0] : '0;
                div_by_zero <= dz;
                overflow    <= ov;
            end
        end else if (ce && state == RUN) begin
            p   <= p_nxt;
            lq  <= {lq[quot_WIDTH-2:0], q_bit};
            cnt <= cnt == '0 ? cnt : cnt - 1'b1;
            if (last) begin
                quot        <= {lq[quot_WIDTH-2:0], q_bit};
                rem         <= p_nxt[rem_WIDTH-1:0];
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha3_256_hls_udiv_59ns_31ns_29_seq.sv
// tb_sha3_256_hls_udiv_59ns_31ns_29_seq: directed and random checks of the divider against 64-bit arithmetic
module tb_sha3_256_hls_udiv_59ns_31ns_29_seq;
    logic        clk = 1'b0, reset = 1'b0, ce = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [58:0] din0 = '0;
    logic [30:0] din1 = '0;
    logic        in_ready, out_valid, div_by_zero, overflow;
    logic [28:0] quot;
    logic [30:0] rem;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sha3_256_hls_udiv_59ns_31ns_29_seq dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din0       (din0),
        .din1       (din1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [58:0] a, input logic [30:0] b,
                          input bit toggle, input int hold);
        logic [63:0] eq, er;
        bit          edz, eov;
        int          n, g;
        edz = b == 0;
        eov = 1'b0;
        eq  = 64'h1FFF_FFFF;
        er  = edz ? 64'(a[30:0]) : 64'd0;
        if (!edz) begin
            eov = (64'(a) / 64'(b)) > 64'h1FFF_FFFF;
            if (!eov) begin
                eq = 64'(a) / 64'(b);
                er = 64'(a) % 64'(b);
            end
        end
        check({tag, ".in_ready_pre"}, in_ready, 1);
        ce = 1'b1; in_valid = 1'b1; din0 = a; din1 = b;
        tick();
        in_valid = 1'b0;
        n = 1; g = 0;
        while (!out_valid && g < 500) begin
            ce = toggle ? 1'($urandom) : 1'b1;
            tick();
            if (ce) n++;
            g++;
        end
        ce = 1'b1;
        check({tag, ".latency"}, n, (edz || eov) ? 1 : 30);
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".quot"}, quot, eq);
        check({tag, ".rem"}, rem, er);
        check({tag, ".dz"}, div_by_zero, edz);
        check({tag, ".ov"}, overflow, eov);
        if (!edz && !eov) begin
            check({tag, ".identity"}, 64'(quot) * 64'(b) + 64'(rem), 64'(a));
            check({tag, ".rem_lt"}, rem < b, 1);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_ready"}, in_ready, 0);
            check({tag, ".hold_quot"}, quot, eq);
            check({tag, ".hold_rem"}, rem, er);
        end
        ce = 1'b0; out_ready = 1'b1;
        tick();
        check({tag, ".ce_blocks_hs"}, out_valid, 1);
        ce = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, out_valid, 0);
        check({tag, ".post_ready"}, in_ready, 1);
        check({tag, ".post_quot"}, quot, eq);
        check({tag, ".post_rem"}, rem, er);
    endtask

    initial begin
        logic [58:0] a;
        logic [30:0] b;
        logic [28:0] q;
        tick();
        tick();
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.quot", quot, 0);
        check("rst.rem", rem, 0);
        check("rst.flags", {div_by_zero, overflow}, 0);
        reset = 1'b1; ce = 1'b1;
        tick();

        run_op("roundtrip", 59'(64'h0ABCDEF * 64'h1234_5678), 31'h1234_5678, 1'b0, 0);
        check("roundtrip.exact_q", quot, 29'h0ABCDEF);
        run_op("rem7", 59'd1000003, 31'd7, 1'b0, 5);
        check("rem7.q", quot, 142857);
        check("rem7.r", rem, 4);
        run_op("divzero", 59'h155, 31'd0, 1'b0, 1);
        run_op("ovf", 59'h1 << 58, 31'd1, 1'b0, 0);
        run_op("ovf_edge", 59'h1FFF_FFFF, 31'd1, 1'b0, 0);
        run_op("ovf_just", 59'h2000_0000, 31'd1, 1'b0, 0);
        run_op("ce_toggle", 59'(64'h0ABCDEF * 64'h1234_5678) + 59'd5, 31'h1234_5678, 1'b1, 0);

        ce = 1'b1; in_valid = 1'b1; din0 = 59'd123456789; din1 = 31'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 1);
        check("midrst.quot", quot, 0);
        tick();
        reset = 1'b1;
        tick();
        check("midrst.still_idle", out_valid, 0);
        run_op("after_rst", 59'd100, 31'd9, 1'b0, 0);
        check("after_rst.q", quot, 11);
        check("after_rst.r", rem, 1);

        for (int k = 0; k < 16; k++) begin
            b = 31'($urandom);
            if (k % 4 == 3) b = 31'($urandom_range(0, 3));
            q = 29'($urandom);
            if (k % 2 == 0 && b != 0)
                a = 59'(64'(q) * 64'(b) + 64'($urandom % 32'(b)));
            else
                a = {27'($urandom), 32'($urandom)};
            run_op($sformatf("rand%0d", k), a, b, k % 3 == 0, k % 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
